dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU load/store stage; port 1 is the DMA/program loader.
- Round-robin arbitration, one transaction accepted per cycle.
- Optional lock lets a requester own the memory for back-to-back atomic sequences.
- Sits between the requesters and the data memory. It drives the memory's address, write-enable and write-data inputs and samples its combinational read data.

Parameters:
- ADDRESS_WIDTH, 16, word-address bits used by the memory.
- DATA_WIDTH, 32, data width and memory address-bus width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port accept; one-hot or zero.
- req_we  in  2  per-port write (1) / read (0).
- req_lock  in  2  per-port hold-grant request.
- req_addr0, req_addr1  in  ADDRESS_WIDTH  per-port address.
- req_wdata0, req_wdata1  in  DATA_WIDTH  per-port write data.
- rsp_valid  out  2  per-port response strobe; no backpressure.
- rsp_rdata  out  DATA_WIDTH  response data, shared, qualified by rsp_valid.
- mem_addr  out  DATA_WIDTH  to memory address input; zero-extended req_addr.
- mem_wen  out  1  memory write enable.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory combinational read data.

Behaviour:
- Handshake: a transfer on port i occurs in a cycle where req_valid[i] and req_ready[i] are both 1. Requester holds all req_* fields stable until accepted.
- req_ready is combinational from req_valid, state and rr_ptr. At most one bit is set per cycle.
- Memory drive:
  - mem_addr, mem_wdata: combinational mux of the granted port's fields. Port 0's fields when there is no grant.
  - mem_wen = transfer & req_we of the granted port. Memory writes at the same clock edge.
- Response:
  - A transfer in cycle T gives rsp_valid[i]=1 for exactly cycle T+1.
  - Read: rsp_rdata = mem_rdata registered at end of T.
  - Write: rsp_rdata = 0.
  - Latency is 1 cycle for both. Full throughput: a new transfer is allowed in T+1.
- State machine (state_t): IDLE, LOCK0, LOCK1.
  - IDLE:
    - Only one port valid: that port wins.
    - Both valid: port rr_ptr wins. rr_ptr resets to 0.
    - After any transfer from port i, rr_ptr <= ~i.
    - If the winner also has req_lock=1, go to LOCKi.
  - LOCKi:
    - Only port i can be granted; the other port's req_ready=0 regardless of its valid.
    - A transfer from i with req_lock=1 stays in LOCKi.
    - A transfer from i with req_lock=0 returns to IDLE. That is the last locked access; rr_ptr <= ~i.
    - If req_valid[i]=0, stay in LOCKi with no grant.
  - No timeout on lock; the requester is responsible for releasing it.
- Simultaneous events:
  - Both valid in IDLE with rr_ptr=1: port 1 is granted; port 0 is granted next cycle if still valid.
  - Port i releases lock in the same cycle the other port is valid: the other port waits one cycle, then is granted from IDLE, since rr_ptr now points at it.
- Reset, applied synchronously:
  - state=IDLE, rr_ptr=0, rsp_valid=0, rsp_rdata=0.
  - A response pending from the previous cycle is dropped.
  - A lock is released.
  - While rst=1, req_ready=0 and mem_wen=0.
- Width rules: mem_addr upper DATA_WIDTH-ADDRESS_WIDTH bits are 0.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
- Defined: in IDLE, port 0 always wins when both are valid. rr_ptr is not implemented. Lock behaviour is unchanged.
- Undefined: round-robin as above.

Decomposition:
- Package dmem_arb_pkg holds:
  - state_t enum {IDLE, LOCK0, LOCK1}, 2-bit.
  - NUM_PORTS=2, localparam.
  - PORT_CPU=0, PORT_DMA=1.
- Sub-module rr_pick2 is natural: combinational 2-way picker. Inputs are valid[1:0], ptr and fixed-priority select; output is one-hot grant.
- FSM, response register and memory mux stay in dmem_arbiter.

Test Plan:
- Write then read, both on port 0:
  - Port 0 write addr 0x0010 data 0xDEADBEEF. Next cycle port 0 reads 0x0010.
  - Required: rsp_valid[0] on both following cycles; the read response has rsp_rdata=0xDEADBEEF.
  - mem_wen high only in the write cycle; mem_addr=0x00000010.
- Contention, round-robin:
  - Both ports hold reads of 0x1 and 0x2 valid for 4 cycles after reset.
  - Required grants 0,1,0,1. rsp_valid alternates 01,10,01,10 one cycle later.
- Lock:
  - Port 1 issues 3 writes, lock=1,1,0, while port 0 is continuously valid.
  - Required: port 0 req_ready=0 for those 3 transfers; port 0 is granted in the following cycle.
- Lock with gap: port 1 locks, then deasserts valid for 2 cycles.
  - Required: state stays LOCK1; port 0 is never ready; mem_wen=0.
- Reset mid-lock:
  - Assert rst for 1 cycle during LOCK0, with a read response due that cycle.
  - Required: rsp_valid=0 the next cycle; state IDLE; port 1 is granted immediately after.
- Fixed-priority build (DMEM_ARB_FIXED_PRIO_EN): both ports valid for 3 cycles.
  - Required: port 0 granted all 3 cycles; port 1 never ready.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   localparam int NUM_PORTS = 2;
   localparam int PORT_CPU  = 0;
   localparam int PORT_DMA  = 1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way combinational picker: a lone valid requester wins; on contention
// the pointer decides, unless fixed priority forces port 0.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] valid_i,
   input  logic                 ptr_i,
   input  logic                 fixed_prio_i,
   output logic [NUM_PORTS-1:0] grant_o
);

   // one-hot grant from the valid vector and the turn pointer
   always_comb begin
      grant_o = valid_i;
      if (valid_i == 2'b11) begin
         grant_o = (ptr_i && !fixed_prio_i) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU load/store port (0) and the DMA /
// program-loader port (1). Round-robin on contention, optional per-port lock
// for atomic sequences, one-cycle registered response.
// Build option: DMEM_ARB_FIXED_PRIO_EN makes port 0 always win contention
// in IDLE and removes the round-robin pointer.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_PORTS-1:0]     req_valid,
   output logic [NUM_PORTS-1:0]     req_ready,
   input  logic [NUM_PORTS-1:0]     req_we,
   input  logic [NUM_PORTS-1:0]     req_lock,
   input  logic [ADDRESS_WIDTH-1:0] req_addr0,
   input  logic [ADDRESS_WIDTH-1:0] req_addr1,
   input  logic [DATA_WIDTH-1:0]    req_wdata0,
   input  logic [DATA_WIDTH-1:0]    req_wdata1,
   output logic [NUM_PORTS-1:0]     rsp_valid,
   output logic [DATA_WIDTH-1:0]    rsp_rdata,
   output logic [DATA_WIDTH-1:0]    mem_addr,
   output logic                     mem_wen,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata
);

   state_t                   state_q;
   logic [NUM_PORTS-1:0]     rsp_valid_q;
   logic [DATA_WIDTH-1:0]    rsp_rdata_q;
   logic [DATA_WIDTH-1:0]    rsp_rdata_d;
   logic [NUM_PORTS-1:0]     pick_grant;
   logic                     rr_ptr;
   logic                     fixed_prio;
   logic                     xfer;
   logic                     grant_port;
   logic                     we_sel;
   logic                     lock_sel;
   logic [ADDRESS_WIDTH-1:0] addr_sel;

`ifdef DMEM_ARB_FIXED_PRIO_EN
   assign rr_ptr     = 1'b0;
   assign fixed_prio = 1'b1;
`else
   logic rr_ptr_q;

   assign rr_ptr     = rr_ptr_q;
   assign fixed_prio = 1'b0;

   // turn pointer: after a transfer from port i the other port has priority
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= 1'b0;
      end else if (xfer) begin
         rr_ptr_q <= ~grant_port;
      end
   end
`endif

   rr_pick2 u_pick (
      .valid_i      (req_valid),
      .ptr_i        (rr_ptr),
      .fixed_prio_i (fixed_prio),
      .grant_o      (pick_grant)
   );

   // accept: picker result when idle, only the owner while locked, none in reset
   always_comb begin
      req_ready = '0;
      if (!rst) begin
         case (state_q)
            LOCK0:   req_ready[PORT_CPU] = req_valid[PORT_CPU];
            LOCK1:   req_ready[PORT_DMA] = req_valid[PORT_DMA];
            default: req_ready = pick_grant;
         endcase
      end
   end

   // ready is only ever raised on a valid port, so any ready bit is a transfer
   assign xfer       = |req_ready;
   assign grant_port = req_ready[PORT_DMA];
   assign we_sel     = req_we[grant_port];
   assign lock_sel   = req_lock[grant_port];
   assign addr_sel   = grant_port ? req_addr1 : req_addr0;

   assign mem_addr   = DATA_WIDTH'(addr_sel);
   assign mem_wdata  = grant_port ? req_wdata1 : req_wdata0;
   assign mem_wen    = xfer & we_sel;

   // writes return zero data; reads capture the memory's combinational output
   assign rsp_rdata_d = (xfer && !we_sel) ? mem_rdata : '0;

   // lock FSM and response register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= req_ready;
         rsp_rdata_q <= rsp_rdata_d;
         if (xfer) begin
            if (lock_sel) begin
               state_q <= grant_port ? LOCK1 : LOCK0;
            end else begin
               state_q <= IDLE;
            end
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule
